// File: rtl/mdu.sv
// mdu: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on magnitudes for N cycles, then applies signs in a single fix-up cycle.
module mdu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         whi,
    input  logic         wlo,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t        state_q, state_d;
    logic          div_q, div_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          dz_q, dz_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  opd_q, opd_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic          sgn;
    logic [N-1:0]  abs_a, abs_b;
    logic [N:0]    msum;
    logic [N:0]    rem_sh;
    logic          ge;
    logic [2*N-1:0] mul_nxt, div_nxt;
    always_comb begin
        sgn     = ~op[0];
        abs_a   = (sgn && a[N-1]) ? -a : a;
        abs_b   = (sgn && b[N-1]) ? -b : b;
        // Multiplier sits in the low half of acc and is consumed LSB first.
        msum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_nxt = {msum, acc_q[N-1:1]};
        // Dividend sits in the low half and shifts into the remainder MSB first.
        rem_sh  = acc_q[2*N-1:N-1];
        ge      = rem_sh >= {1'b0, opd_q};
        div_nxt = ge ? {rem_sh[N-1:0] - opd_q, acc_q[N-2:0], 1'b1}
                     : {rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
        state_d = state_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    div_d   = op[1];
                    opd_d   = op[1] ? abs_b : abs_a;
                    acc_d   = {{N{1'b0}}, op[1] ? abs_a : abs_b};
                    negq_d  = sgn & (a[N-1] ^ b[N-1]);
                    negr_d  = sgn & a[N-1];
                    dz_d    = b == '0;
                    cnt_d   = CW'(N);
                    state_d = RUN;
                end else begin
                    hi_d = whi ? wdata : hi_q;
                    lo_d = wlo ? wdata : lo_q;
                end
            end
            RUN: begin
                acc_d   = div_q ? div_nxt : mul_nxt;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? FIX : RUN;
            end
            FIX: begin
                if (div_q) begin
                    lo_d = dz_q ? '1 : (negq_q ? -acc_q[N-1:0] : acc_q[N-1:0]);
                    hi_d = negr_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
                end else begin
                    {hi_d, lo_d} = negq_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
